// File: rtl/ex_div_unit_if.sv
// Handshake/data bundle between the EX-stage pipeline control and the iterative divider.
interface ex_div_unit_if #(
  parameter int XLEN = 32
);
  logic            div_req;
  logic [1:0]      div_op;
  logic [XLEN-1:0] src_j;
  logic [XLEN-1:0] src_k;
  logic            ex_adv;
  logic            ex_cancel;
  logic            ex_exe_out_valid;
  logic [XLEN-1:0] div_result;
  logic            div_busy;

  modport master (
    output div_req, div_op, src_j, src_k, ex_adv, ex_cancel,
    input  ex_exe_out_valid, div_result, div_busy
  );

  modport slave (
    input  div_req, div_op, src_j, src_k, ex_adv, ex_cancel,
    output ex_exe_out_valid, div_result, div_busy
  );
endinterface

// File: rtl/ex_div_unit.sv
// Restoring radix-2 divider for div.w/mod.w/div.wu/mod.wu; holds ex_exe_out_valid low
// while a divide is in flight so the hazard controller freezes the front end.
module ex_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          reset,
  ex_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_abs_d;
  logic [XLEN-1:0] r_result;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_want_mod;

  logic            w_signed;
  logic            w_j_neg;
  logic            w_k_neg;
  logic [XLEN-1:0] w_abs_j;
  logic [XLEN-1:0] w_abs_k;
  logic            w_start;
  logic            w_dz;
  logic [XLEN+1:0] w_trial;
  logic            w_fits;
  logic [XLEN:0]   w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_signed = ~bus.div_op[1];
  assign w_j_neg  = w_signed & bus.src_j[XLEN-1];
  assign w_k_neg  = w_signed & bus.src_k[XLEN-1];
  assign w_abs_j  = w_j_neg ? (-bus.src_j) : bus.src_j;
  assign w_abs_k  = w_k_neg ? (-bus.src_k) : bus.src_k;
  assign w_start  = bus.div_req & ~bus.ex_cancel;
  assign w_dz     = (bus.src_k == '0);

  // Partial remainder stays below the divisor, so the shifted value fits in XLEN+1 bits
  // and bit XLEN+1 of the trial subtraction is the borrow.
  assign w_trial   = {r_rem, r_quo[XLEN-1]} - {2'b00, r_abs_d};
  assign w_fits    = ~w_trial[XLEN+1];
  assign w_rem_nxt = w_fits ? w_trial[XLEN:0] : {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_fits};
  assign w_quo_fix = r_q_neg ? (-w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix = r_r_neg ? (-w_rem_nxt[XLEN-1:0]) : w_rem_nxt[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.ex_cancel) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.div_req) w_state_nxt = w_dz ? ST_DONE : ST_CALC;
        ST_CALC: if (r_cnt == '0) w_state_nxt = ST_DONE;
        ST_DONE: if (bus.ex_adv) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_abs_d    <= '0;
      r_result   <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_want_mod <= 1'b0;
    end else if (bus.ex_cancel) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_abs_d    <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_want_mod <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_abs_d    <= w_abs_k;
            r_quo      <= w_abs_j;
            r_rem      <= '0;
            r_cnt      <= CNT_W'(XLEN - 1);
            r_q_neg    <= w_j_neg ^ w_k_neg;
            r_r_neg    <= w_j_neg;
            r_want_mod <= bus.div_op[0];
            // Divide by zero bypasses the iteration and returns raw operands.
            if (w_dz) r_result <= bus.div_op[0] ? bus.src_j : '1;
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_result <= r_want_mod ? w_rem_fix : w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.ex_exe_out_valid = ~bus.div_req | (r_state == ST_DONE);
  assign bus.div_result       = r_result;
  assign bus.div_busy         = (r_state == ST_CALC);

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: vector table for arithmetic/latency, plus hand sequences
// for reset, hold, back-to-back, cancel and mid-operation reset.
module tb_ex_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_div_unit_if #(.XLEN(32)) bus ();

  ex_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] j;
    logic [31:0] k;
    logic [31:0] exp_res;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+2 of the first cycle with valid high.
  task automatic start_and_wait(input logic [1:0] op, input logic [31:0] j,
                                input logic [31:0] k, output int lat);
    bus.div_req   = 1'b1;
    bus.div_op    = op;
    bus.src_j     = j;
    bus.src_k     = k;
    bus.ex_adv    = 1'b0;
    bus.ex_cancel = 1'b0;
    lat = 0;
    #1;
    while (!bus.ex_exe_out_valid && lat < 60) begin
      @(posedge clk);
      #2;
      lat++;
    end
  endtask

  // Called at posedge+2; returns at posedge+1 with the unit back in IDLE.
  task automatic finish_adv();
    bus.ex_adv = 1'b1;
    @(posedge clk);
    #1;
    bus.ex_adv  = 1'b0;
    bus.div_req = 1'b0;
  endtask

  // Stimulus itself must never drop div_req mid-operation without a cancel.
  always @(posedge clk) begin
    if (!reset && bus.div_busy && !bus.div_req && !bus.ex_cancel) begin
      errors++;
      $display("FAIL protocol div_req dropped during CALC");
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    checks = 0;
    errors = 0;

    vecs[0]  = '{2'b00, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "divw_m7_2"};
    vecs[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "modw_m7_2"};
    vecs[2]  = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 33, "divwu_max_16"};
    vecs[3]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 33, "modwu_100_7"};
    vecs[4]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "divw_ovf"};
    vecs[5]  = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, "modw_ovf"};
    vecs[6]  = '{2'b00, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1,  "divw_dz"};
    vecs[7]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 1,  "modwu_dz"};
    vecs[8]  = '{2'b00, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, "divw_100_m7"};
    vecs[9]  = '{2'b01, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 33, "modw_m100_7"};
    vecs[10] = '{2'b10, 32'h00000007, 32'hFFFFFFF9, 32'h00000000, 33, "divwu_7_big"};
    vecs[11] = '{2'b01, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 1,  "modw_dz_neg"};

    reset         = 1'b1;
    bus.div_req   = 1'b0;
    bus.div_op    = 2'b00;
    bus.src_j     = '0;
    bus.src_k     = '0;
    bus.ex_adv    = 1'b0;
    bus.ex_cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      #1;
      chk("rst_valid", {31'd0, bus.ex_exe_out_valid}, 32'd1);
      chk("rst_result", bus.div_result, 32'd0);
      chk("rst_busy", {31'd0, bus.div_busy}, 32'd0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 12; i++) begin
      start_and_wait(vecs[i].op, vecs[i].j, vecs[i].k, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_res"}, bus.div_result, vecs[i].exp_res);
      chk({vecs[i].name, "_busy"}, {31'd0, bus.div_busy}, 32'd0);
      finish_adv();
      @(posedge clk);
      #1;
    end

    // Hold in DONE, then back-to-back start the cycle after ex_adv.
    start_and_wait(2'b00, 32'hFFFFFFF9, 32'h00000002, lat);
    chk("hold_lat", 32'(lat), 32'd33);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      chk("hold_valid", {31'd0, bus.ex_exe_out_valid}, 32'd1);
      chk("hold_result", bus.div_result, 32'hFFFFFFFD);
    end
    finish_adv();
    start_and_wait(2'b10, 32'd20, 32'd3, lat);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_res", bus.div_result, 32'd6);
    finish_adv();

    // Cancel at cycle 10 of the operation.
    bus.div_req = 1'b1;
    bus.div_op  = 2'b00;
    bus.src_j   = 32'd100;
    bus.src_k   = 32'd7;
    repeat (10) @(posedge clk);
    #2;
    chk("cancel_busy_before", {31'd0, bus.div_busy}, 32'd1);
    chk("cancel_valid_before", {31'd0, bus.ex_exe_out_valid}, 32'd0);
    bus.ex_cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.ex_cancel = 1'b0;
    bus.div_req   = 1'b0;
    #1;
    chk("cancel_busy_after", {31'd0, bus.div_busy}, 32'd0);
    chk("cancel_valid_after", {31'd0, bus.ex_exe_out_valid}, 32'd1);
    @(posedge clk);
    #1;
    start_and_wait(2'b00, 32'd9, 32'd3, lat);
    chk("post_cancel_lat", 32'(lat), 32'd33);
    chk("post_cancel_res", bus.div_result, 32'd3);
    finish_adv();

    // Reset in the middle of CALC.
    bus.div_req = 1'b1;
    bus.div_op  = 2'b00;
    bus.src_j   = 32'd100;
    bus.src_k   = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_busy_before", {31'd0, bus.div_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.div_req = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.ex_exe_out_valid}, 32'd1);
    chk("midrst_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("midrst_result", bus.div_result, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    start_and_wait(2'b11, 32'd100, 32'd7, lat);
    chk("post_rst_lat", 32'(lat), 32'd33);
    chk("post_rst_res", bus.div_result, 32'd2);
    finish_adv();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit integer divider in the EX stage, implementing LoongArch `div.w`, `mod.w`, `div.wu` and `mod.wu`. It produces `ex_exe_out_valid`, the EX-side completion signal consumed by the pipeline hazard controller. While a divide is in flight the signal is held low, so the controller freezes IF1..ID/EX and inserts a bubble into EX/MM1. The unit releases the signal for exactly the cycles in which its result is ready, and returns to idle when the instruction leaves EX.

## Interface
Parameters
- `XLEN`, 32, operand and result width. Only 32 is supported.
- `CNT_W`, 5, iteration counter width; must equal log2(XLEN).

Ports
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `div_req`  in  1  EX-stage instruction is a divide/modulo. Held stable with the operands while EX is frozen.
- `div_op`  in  2  operation select: 00 `div.w`, 01 `mod.w`, 10 `div.wu`, 11 `mod.wu`.
- `src_j`  in  32  dividend (rj).
- `src_k`  in  32  divisor (rk).
- `ex_adv`  in  1  the EX instruction leaves EX this cycle (EX/MM1 register write enable).
- `ex_cancel`  in  1  the EX instruction is killed (exception or flush); aborts any operation.
- `ex_exe_out_valid`  out  1  EX result valid; low stalls the pipeline.
- `div_result`  out  32  quotient or remainder; meaningful only in DONE.
- `div_busy`  out  1  high in CALC (for performance counters and debug).

## Operation
- Registered state: `state` (IDLE, CALC, DONE), `cnt[CNT_W-1:0]`, remainder accumulator `rem[32:0]`, quotient shift register `quo[31:0]`, `abs_d[31:0]`, and latched flags `q_neg`, `r_neg`, `want_mod`, `dz`.
- `ex_exe_out_valid` is combinational: it is `!div_req | (state==DONE)`. The unit never stalls non-divide instructions.

**IDLE**
- On `div_req & !ex_cancel`, latch the absolute values of the operands. Absolute values are taken only when `div_op[1]==0` (signed ops).
- Latch the sign flags:
  - `q_neg` = sign(j) XOR sign(k)
  - `r_neg` = sign(j)
- Clear `rem`. Load `quo` with abs(j). Set `cnt` to 31.
- If `src_k==0`, set `dz=1` and go directly to DONE. Otherwise go to CALC.

**CALC**
- Each cycle performs one restoring step:
  - `rem` is shifted left by one, taking in the MSB of `quo`.
  - Trial-subtract `abs_d`. If the result is non-negative, keep it and shift a 1 into `quo`; otherwise shift a 0.
- `cnt` decrements each cycle. On the step with `cnt==0`, go to DONE and register the sign-corrected result into `div_result`:
  - quotient: negated if `q_neg` and signed
  - remainder: negated if `r_neg` and signed
- `want_mod` selects remainder versus quotient.

**DONE**
- `div_result` is held stable.
- On `ex_adv`, go to IDLE.
- If `ex_adv` is low (for example, a higher-priority stall), stay in DONE indefinitely.

**Cancel and reset**
- `ex_cancel` in any state forces IDLE next cycle and discards all partial state. It takes priority over `ex_adv` and over the start condition.
- `reset` forces: `state`=IDLE, `cnt`=0, `rem`=0, `quo`=0, `div_result`=0, all flags 0.
- After reset with `div_req`=0: `ex_exe_out_valid`=1 and `div_busy`=0.

**Arithmetic rules**
- Divide by zero: quotient is 32'hFFFFFFFF and remainder equals `src_j` unchanged, for both signed and unsigned ops. No sign correction is applied.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is the natural two's-complement wrap; no trap is raised.
- Sign rules: remainder takes the sign of the dividend, and the quotient truncates toward zero.

**Protocol**
- `div_req` dropping while in CALC/DONE without `ex_cancel` is illegal. The bench asserts it never occurs.

## Timing
- Cycle 0: `div_req` rises with state IDLE. `ex_exe_out_valid`=0; operands latched.
- Cycles 1..32: CALC, one quotient bit per cycle. `ex_exe_out_valid`=0, `div_busy`=1.
- Cycle 33: DONE, `ex_exe_out_valid`=1, `div_result` valid. Latency is 33 cycles from request to valid.
- Divide by zero: DONE at cycle 1, valid at cycle 1.
- Back-to-back divides: `ex_adv` in cycle N gives IDLE at N+1. A new `div_req` at N+1 starts immediately, with no dead cycle beyond the IDLE start cycle.
- `ex_cancel` at cycle N gives IDLE at N+1. `ex_exe_out_valid` at N+1 follows the new `div_req` value.

## Test plan
- After reset, `div_req`=0 → `ex_exe_out_valid`=1, `div_result`=0, `div_busy`=0; no state change for 10 cycles.
- `div.w` with j=-7 (0xFFFFFFF9), k=2 → valid low for cycles 0..32, high at 33, `div_result`=0xFFFFFFFD. Repeat as `mod.w` → 0xFFFFFFFF.
- `div.wu` with j=0xFFFFFFFF, k=0x10 → 0x0FFFFFFF. `mod.wu` with j=100, k=7 → 2. Then signed overflow 0x80000000 / 0xFFFFFFFF with `div.w` → 0x80000000, and `mod.w` → 0.
- Divide by zero: `div.w` with j=0x1234, k=0 → valid at cycle 1, result 0xFFFFFFFF. `mod.wu` with the same operands → 0x1234.
- Hold and back-to-back: after completion keep `ex_adv`=0 for 5 cycles → result and valid held. Pulse `ex_adv`, then present `div.wu` 20/3 next cycle → valid 33 cycles later, result 6.
- `ex_cancel` at cycle 10 of CALC → IDLE next cycle, `div_busy`=0. A fresh `div.w` 9/3 then completes in 33 cycles with 3. Also assert `reset` mid-CALC → all outputs at their reset values the following cycle.
